// File: rtl/msg_uart_pkg.sv
// Shared constants for the message UART transmitter: register indices,
// serializer states and STATUS bit positions.
package msg_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_COUNT = 4;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_OVF_CLR = 1;

  // The STATUS count field is 4 bits wide; deeper FIFOs report 15 when fuller.
  function automatic logic [3:0] sat_count4(input int unsigned occ);
    return (occ > 32'd15) ? 4'hF : occ[3:0];
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with first-word fall-through output; a push on full is taken
// only when a pop happens in the same cycle.
module uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: storage has no reset; only pointers and count define validity,
  // which keeps the array mappable to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/msg_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus register decode, byte FIFO and
// LSB-first serializer with glitch-free registered outputs.
module msg_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Sel,
  input  logic        MemWrite,
  input  logic [3:0]  Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx,
  output logic        irq_empty
);

  import msg_uart_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  logic          write, read, push, ctrl_write;
  logic [1:0]    idx;
  logic          pop, full, empty, start_frame;
  logic [7:0]    dout;
  logic [CW-1:0] count, count_next;
  uart_state_t   state, state_next;
  logic [BW-1:0] baud;
  logic          baud_done;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          en, ovf, busy;
  logic [31:0]   status_word;
  logic          unused_bits;

  assign write       = Sel & MemWrite;
  assign read        = Sel & ~MemWrite;
  assign idx         = Addr[3:2];
  assign push        = write && (idx == REG_DATA);
  assign ctrl_write  = write && (idx == REG_CTRL);
  assign busy        = (state != IDLE);
  assign baud_done   = (baud == BW'(CLKS_PER_BIT - 1));
  assign start_frame = en && !empty;
  assign count_next  = count + CW'(push && (!full || pop)) - CW'(pop);
  assign unused_bits = ^{Addr[1:0], WriteData[31:8]};

  always_comb begin
    status_word           = '0;
    status_word[ST_FULL]  = full;
    status_word[ST_EMPTY] = empty;
    status_word[ST_BUSY]  = busy;
    status_word[ST_OVF]   = ovf;
    status_word[ST_COUNT +: 4] = sat_count4(32'(count));
  end

  uart_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (WriteData[7:0]),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE:  if (start_frame) begin state_next = START; pop = 1'b1; end
      START: if (baud_done) state_next = DATA;
      DATA:  if (baud_done && bit_idx == 3'd7) state_next = STOP;
      STOP:  if (baud_done) begin
               if (start_frame) begin state_next = START; pop = 1'b1; end
               else state_next = IDLE;
             end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud      <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      tx        <= 1'b1;
      irq_empty <= 1'b1;
    end else begin
      state     <= state_next;
      irq_empty <= (count_next == '0) && (state_next == IDLE);
      baud      <= (state == IDLE || baud_done) ? '0 : baud + BW'(1);
      if (pop) begin
        shreg <= dout;
        tx    <= 1'b0;
      end else if (baud_done) begin
        case (state)
          START: begin tx <= shreg[0]; bit_idx <= '0; end
          DATA:  if (bit_idx == 3'd7) tx <= 1'b1;
                 else begin
                   tx      <= shreg[1];
                   shreg   <= shreg >> 1;
                   bit_idx <= bit_idx + 3'd1;
                 end
          default: tx <= 1'b1;
        endcase
      end
    end
  end

  // Control register and bus read path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en       <= 1'b1;
      ovf      <= 1'b0;
      ReadData <= '0;
    end else begin
      if (ctrl_write) en <= WriteData[CTRL_EN];
      if (ctrl_write && WriteData[CTRL_OVF_CLR]) ovf <= 1'b0;
      else if (push && full && !pop)             ovf <= 1'b1;
      if (read) begin
        case (idx)
          REG_STATUS: ReadData <= status_word;
          REG_CTRL:   ReadData <= {31'b0, en};
          default:    ReadData <= '0;
        endcase
      end
    end
  end

endmodule
